// File: rtl/seg_scan_if.sv
// seg_scan_if
//   Bundles the host-facing signals of the 7-segment scan driver.
//   master : the register block that supplies the value to show.
//   slave  : the scan driver itself.
//   Host -> display : data, dp, blank, load, lzs, bright
//   Display -> host : which, seg, en, count, digit
interface seg_scan_if #(
  parameter int DIGITS   = 8,
  parameter int DIV_W    = 11,
  parameter int BRIGHT_W = 3
);
  localparam int WHICH_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [4*DIGITS-1:0] data;
  logic [DIGITS-1:0]   dp;
  logic [DIGITS-1:0]   blank;
  logic                load;
  logic                lzs;
  logic [BRIGHT_W-1:0] bright;

  logic [WHICH_W-1:0]  which;
  logic [7:0]          seg;
  logic                en;
  logic [DIV_W-1:0]    count;
  logic [3:0]          digit;

  modport master (
    output data, dp, blank, load, lzs, bright,
    input  which, seg, en, count, digit
  );

  modport slave (
    input  data, dp, blank, load, lzs, bright,
    output which, seg, en, count, digit
  );
endinterface

// File: rtl/seg_scan_display.sv
// seg_scan_display
//   Time-multiplexed 7-segment scan driver for a common-bus digit array.
//   A load-strobed shadow copy of data/dp/blank is what gets displayed, so
//   the host can update its register at any time without tearing a frame.
//   Ports:
//     clk   : system clock, rising edge
//     rst_n : asynchronous active-low reset
//     bus   : seg_scan_if slave modport (data/dp/blank/load/lzs/bright in,
//             which/seg/en/count/digit out)
//   seg is active high: bit 7 = dp, bits 6:0 = g,f,e,d,c,b,a.
module seg_scan_display #(
  parameter int DIGITS   = 8,
  parameter int DIV_W    = 11,
  parameter int BRIGHT_W = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  seg_scan_if.slave   bus
);

  localparam int WHICH_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [WHICH_W-1:0] LAST_DIGIT = WHICH_W'(DIGITS - 1);

  // Scan state
  logic [DIV_W-1:0]    count_q, count_d;
  logic [WHICH_W-1:0]  which_q, which_d;

  // Shadow copy of the host value
  logic [4*DIGITS-1:0] sh_data_q, sh_data_d;
  logic [DIGITS-1:0]   sh_dp_q, sh_dp_d;
  logic [DIGITS-1:0]   sh_blank_q, sh_blank_d;

  // Decode path
  logic [3:0]          digit_nib;
  logic [6:0]          hex_pat;
  logic [DIGITS-1:0]   lead_zero;
  logic                suppress;
  logic                drive_en;
  logic [7:0]          seg_out;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    count_d    = count_q + DIV_W'(1);
    which_d    = which_q;
    sh_data_d  = sh_data_q;
    sh_dp_d    = sh_dp_q;
    sh_blank_d = sh_blank_q;

    // Advance one digit per prescaler period; explicit wrap keeps the index
    // in range when DIGITS is not a power of two.
    if (&count_q) begin
      which_d = (which_q == LAST_DIGIT) ? '0 : which_q + WHICH_W'(1);
    end

    if (bus.load) begin
      sh_data_d  = bus.data;
      sh_dp_d    = bus.dp;
      sh_blank_d = bus.blank;
    end
  end

  // NOTE: the shadow registers are ordinary flops, not a memory, so they are
  // reset along with the scan state; a fresh reset shows 0 on every digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      which_q    <= '0;
      sh_data_q  <= '0;
      sh_dp_q    <= '0;
      sh_blank_q <= '0;
    end else begin
      // NOTE: state updates use non-blocking assignment so every flop samples
      // the pre-edge values regardless of statement order.
      count_q    <= count_d;
      which_q    <= which_d;
      sh_data_q  <= sh_data_d;
      sh_dp_q    <= sh_dp_d;
      sh_blank_q <= sh_blank_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Leading-zero detection: lead_zero[i] is set when every shadow nibble from
  // the most significant digit down to digit i is zero.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic upper_zero;
    // NOTE: blocking assignment is intended here; upper_zero carries a
    // running AND from one loop iteration to the next.
    upper_zero = 1'b1;
    lead_zero  = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      upper_zero   = upper_zero & (sh_data_q[4*i +: 4] == 4'h0);
      lead_zero[i] = upper_zero;
    end
  end

  // ---------------------------------------------------------------------------
  // Digit decode and output gating
  // ---------------------------------------------------------------------------
  assign digit_nib = sh_data_q[{which_q, 2'b00} +: 4];

  always_comb begin
    hex_pat = 7'h00;
    case (digit_nib)
      4'h0: hex_pat = 7'h3F;
      4'h1: hex_pat = 7'h06;
      4'h2: hex_pat = 7'h5B;
      4'h3: hex_pat = 7'h4F;
      4'h4: hex_pat = 7'h66;
      4'h5: hex_pat = 7'h6D;
      4'h6: hex_pat = 7'h7D;
      4'h7: hex_pat = 7'h07;
      4'h8: hex_pat = 7'h7F;
      4'h9: hex_pat = 7'h6F;
      4'hA: hex_pat = 7'h77;
      4'hB: hex_pat = 7'h7C;
      4'hC: hex_pat = 7'h39;
      4'hD: hex_pat = 7'h5E;
      4'hE: hex_pat = 7'h79;
      4'hF: hex_pat = 7'h71;
      default: hex_pat = 7'h00;
    endcase
  end

  // Digit 0 always shows, so a value of zero still displays "0".
  assign suppress = bus.lzs && (which_q != '0) && lead_zero[which_q];

  // PWM: the digit is driven while the top bits of the prescaler are at or
  // below the brightness setting within each dwell.
  assign drive_en = (count_q[DIV_W-1 -: BRIGHT_W] <= bus.bright);

  always_comb begin
    seg_out = 8'h00;
    if (drive_en && !sh_blank_q[which_q]) begin
      seg_out[7]   = sh_dp_q[which_q];
      seg_out[6:0] = suppress ? 7'h00 : hex_pat;
    end
  end

  assign bus.which = which_q;
  assign bus.count = count_q;
  assign bus.digit = digit_nib;
  assign bus.en    = drive_en;
  assign bus.seg   = seg_out;

endmodule

// File: tb/tb_seg_scan_display.sv
// tb_seg_scan_display
//   Drives two instances side by side: A (DIGITS=8, DIV_W=4, BRIGHT_W=2) and
//   B (DIGITS=5, DIV_W=2, BRIGHT_W=2). A cycle counter since reset plus a copy
//   of the last loaded value is enough to predict every output: the scan
//   position is plain division of the cycle count, and the segment value
//   follows from the display rules applied to the loaded value.
module tb_seg_scan_display;

  logic clk = 1'b0;
  logic rst_n_a = 1'b0;
  logic rst_n_b = 1'b0;
  always #5 clk = ~clk;

  seg_scan_if #(.DIGITS(8), .DIV_W(4), .BRIGHT_W(2)) bus_a ();
  seg_scan_if #(.DIGITS(5), .DIV_W(2), .BRIGHT_W(2)) bus_b ();

  seg_scan_display #(.DIGITS(8), .DIV_W(4), .BRIGHT_W(2)) dut_a (
    .clk   (clk),
    .rst_n (rst_n_a),
    .bus   (bus_a.slave)
  );

  seg_scan_display #(.DIGITS(5), .DIV_W(2), .BRIGHT_W(2)) dut_b (
    .clk   (clk),
    .rst_n (rst_n_b),
    .bus   (bus_b.slave)
  );

  localparam logic [6:0] HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference state
  int          cyc_a, cyc_b;
  logic [31:0] m_data_a, m_data_b;
  logic [7:0]  m_dp_a, m_dp_b, m_blank_a, m_blank_b;

  // Stimulus values
  logic [31:0] d_data;
  logic [7:0]  d_dp, d_blank;
  logic        d_load, d_lzs;
  logic [1:0]  d_bright;

  // Expected segments for digit w given the loaded value and the level inputs.
  function automatic logic [7:0] model_seg(input logic [31:0] shd, input logic [7:0] sdp,
                                           input logic [7:0] sbl, input int digits,
                                           input int w, input logic en, input logic lz);
    logic zero_top;
    logic [3:0] nib;
    zero_top = 1'b1;
    for (int j = w; j < digits; j++)
      if (shd[4*j +: 4] != 4'h0) zero_top = 1'b0;
    nib = shd[4*w +: 4];
    if (!en || sbl[w]) return 8'h00;
    return {sdp[w], (lz && w != 0 && zero_top) ? 7'h00 : HEX[nib]};
  endfunction

  task automatic drive();
    bus_a.data   = d_data;
    bus_a.dp     = d_dp;
    bus_a.blank  = d_blank;
    bus_a.load   = d_load;
    bus_a.lzs    = d_lzs;
    bus_a.bright = d_bright;
    bus_b.data   = d_data[19:0];
    bus_b.dp     = d_dp[4:0];
    bus_b.blank  = d_blank[4:0];
    bus_b.load   = d_load;
    bus_b.lzs    = d_lzs;
    bus_b.bright = d_bright;
  endtask

  task automatic check_a();
    int w, c;
    logic en;
    c  = cyc_a % 16;
    w  = (cyc_a / 16) % 8;
    en = ((c / 4) <= int'(d_bright));
    check("a_count", 32'(bus_a.count), 32'(c));
    check("a_which", 32'(bus_a.which), 32'(w));
    check("a_digit", 32'(bus_a.digit), 32'(m_data_a[4*w +: 4]));
    check("a_en",    32'(bus_a.en),    32'(en));
    check("a_seg",   32'(bus_a.seg),
          32'(model_seg(m_data_a, m_dp_a, m_blank_a, 8, w, en, d_lzs)));
  endtask

  task automatic check_b();
    int w, c;
    logic en;
    c  = cyc_b % 4;
    w  = (cyc_b / 4) % 5;
    en = (c <= int'(d_bright));
    check("b_count", 32'(bus_b.count), 32'(c));
    check("b_which", 32'(bus_b.which), 32'(w));
    check("b_digit", 32'(bus_b.digit), 32'(m_data_b[4*w +: 4]));
    check("b_en",    32'(bus_b.en),    32'(en));
    check("b_seg",   32'(bus_b.seg),
          32'(model_seg(m_data_b, m_dp_b, m_blank_b, 5, w, en, d_lzs)));
  endtask

  initial begin
    logic [31:0] v;
    int nz;
    bit rst_done;
    bit rst_release;

    d_data = '0; d_dp = '0; d_blank = '0; d_load = 1'b0; d_lzs = 1'b0; d_bright = 2'd3;
    drive();
    cyc_a = 0; cyc_b = 0;
    m_data_a = '0; m_dp_a = '0; m_blank_a = '0;
    m_data_b = '0; m_dp_b = '0; m_blank_b = '0;
    rst_done = 1'b0; rst_release = 1'b0;

    // Reset state, checked while reset is still asserted.
    repeat (2) @(posedge clk);
    #1;
    check_a();
    check_b();
    check("a_rst_seg", 32'(bus_a.seg), 32'h3F);

    @(negedge clk);
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;

    for (int cycle = 0; cycle < 1600; cycle++) begin
      // Directed frames first (hex decode, then LZS/dp/blank with lzs on
      // and off), random traffic afterwards.
      d_load = 1'b0;
      if (cycle == 0) begin
        d_data = 32'hFEDC_BA98; d_dp = 8'h00; d_blank = 8'h00;
        d_load = 1'b1; d_lzs = 1'b0; d_bright = 2'd3;
      end else if (cycle == 128) begin
        d_data = 32'h0000_0305; d_dp = 8'h02; d_blank = 8'h04;
        d_load = 1'b1; d_lzs = 1'b1;
      end else if (cycle == 256) begin
        d_lzs = 1'b0;
      end else if (cycle >= 384) begin
        // Keep the host register changing without load most of the time,
        // so a display that bypasses the shadow copy is caught.
        v  = $urandom;
        nz = $urandom_range(0, 8);
        d_data  = (nz == 8) ? 32'h0 : (v >> (4 * nz));
        d_dp    = 8'($urandom);
        d_blank = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
        d_load  = ($urandom_range(0, 15) == 0);
        if (cycle % 64 == 0) d_lzs = 1'($urandom);
        if (cycle % 48 == 0) d_bright = 2'($urandom);
      end
      if (rst_release) begin
        rst_n_b     = 1'b1;
        rst_release = 1'b0;
      end
      drive();

      @(posedge clk);
      cyc_a++;
      cyc_b++;
      if (d_load) begin
        m_data_a = d_data; m_dp_a = d_dp; m_blank_a = d_blank;
        m_data_b = {12'h0, d_data[19:0]};
        m_dp_b   = {3'h0, d_dp[4:0]};
        m_blank_b = {3'h0, d_blank[4:0]};
      end
      #1;
      check_a();
      check_b();

      // Asynchronous reset of B in the middle of digit 3 (count 2).
      if (!rst_done && cycle > 400 && (cyc_b % 20) == 14) begin
        #1 rst_n_b = 1'b0;
        #1;
        cyc_b = 0;
        m_data_b = '0; m_dp_b = '0; m_blank_b = '0;
        check("b_rst_which", 32'(bus_b.which), 32'd0);
        check("b_rst_count", 32'(bus_b.count), 32'd0);
        check("b_rst_seg",   32'(bus_b.seg),   32'h3F);
        rst_done    = 1'b1;
        rst_release = 1'b1;
      end

      @(negedge clk);
    end

    check("b_reset_hit", 32'(rst_done), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
